// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter sitting on the core's store path.
// A store with device code 01 loads the TX data register. A store with
// device code 11 and data bit 0 set starts a frame, but only when the
// transmitter is idle. Busy status is presented on Status_Out so the core
// can poll it through the read path.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   Write_Enable in   store strobe, one cycle per store
//   Select       in   [1:0] device code (01 data, 11 control, 10 RX, 00 none)
//   Write_Data   in   [DATA_WIDTH-1:0] store data
//   Tx           out  serial line, idles high, driven from a flop
//   Tx_Busy      out  high while a frame is in flight
//   Tx_Done      out  one-cycle pulse as the frame ends
//   Status_Out   out  [DATA_WIDTH-1:0] {0..., Tx_Busy}, combinational
//   o_dbg_state  out  [1:0] current FSM state (0 idle, 1 start, 2 data, 3 stop)
//
// Store interface: there is no back-pressure. Every cycle with Write_Enable
// high is a complete store; it is either acted on in that cycle or dropped.
module uart_tx_mmio #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Write_Enable,
  input  logic [1:0]            Select,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Tx,
  output logic                  Tx_Busy,
  output logic                  Tx_Done,
  output logic [DATA_WIDTH-1:0] Status_Out,
  output logic [1:0]            o_dbg_state
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_tx_data;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_tx;
  logic          r_done;

  logic w_data_wr;
  logic w_start_cmd;
  logic w_bit_end;

  assign w_data_wr   = Write_Enable && (Select == 2'b01);
  assign w_start_cmd = Write_Enable && (Select == 2'b11) && Write_Data[0];
  assign w_bit_end   = (r_baud == LAST);

  // The data register is independent of the frame in flight: the shift
  // register holds its own copy, so a reload here never corrupts a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_data <= 8'h00;
    end else if (w_data_wr) begin
      r_tx_data <= Write_Data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= 8'h00;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Starts arriving in any other state are simply not looked at.
          if (w_start_cmd) begin
            r_state <= S_START;
            r_shift <= r_tx_data;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_bit   <= 3'd0;
              r_tx    <= 1'b1;
            end else begin
              // Line takes the next bit on the same edge the shift happens,
              // so Tx never passes through an intermediate value.
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_done  <= 1'b1;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
      endcase
    end
  end

  assign Tx          = r_tx;
  assign Tx_Busy     = (r_state != S_IDLE);
  assign Tx_Done     = r_done;
  assign Status_Out  = {{(DATA_WIDTH-1){1'b0}}, Tx_Busy};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT = 4.
// The reference model describes a frame purely by its start edge and byte:
// the line level at any cycle is derived from the offset into the frame.
module tb_uart_tx_mmio;

  localparam int DW    = 32;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Write_Enable = 1'b0;
  logic [1:0]    Select = 2'b00;
  logic [DW-1:0] Write_Data = '0;
  logic          Tx;
  logic          Tx_Busy;
  logic          Tx_Done;
  logic [DW-1:0] Status_Out;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  uart_tx_mmio #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .Write_Enable (Write_Enable),
    .Select       (Select),
    .Write_Data   (Write_Data),
    .Tx           (Tx),
    .Tx_Busy      (Tx_Busy),
    .Tx_Done      (Tx_Done),
    .Status_Out   (Status_Out),
    .o_dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int         cyc     = 0;
  int         m_e0    = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] m_byte  = 8'h00;

  function automatic logic m_busy();
    int d;
    d = cyc - m_e0;
    return m_valid && (d >= 0) && (d < FRAME);
  endfunction

  function automatic logic m_tx();
    int d;
    d = cyc - m_e0;
    if (!m_valid || d < 0 || d >= FRAME) return 1'b1;
    if (d < CPB) return 1'b0;
    if (d < 9 * CPB) return m_byte[d / CPB - 1];
    return 1'b1;
  endfunction

  function automatic logic m_done();
    return m_valid && ((cyc - m_e0) == FRAME);
  endfunction

  task automatic model_edge(input logic we, input logic [1:0] sel, input logic [DW-1:0] wd);
    int d;
    bit sampled_busy;
    if (!reset) return;
    d = cyc - m_e0;
    // The state seen by this edge is the one left by the previous edge.
    sampled_busy = m_valid && (d >= 1) && (d <= FRAME);
    if (we && sel == 2'b11 && wd[0] && !sampled_busy) begin
      m_e0    = cyc;
      m_valid = 1'b1;
      m_byte  = m_data;
    end
    if (we && sel == 2'b01) m_data = wd[7:0];
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_model();
    check("tx",     {31'b0, Tx},      {31'b0, m_tx()});
    check("busy",   {31'b0, Tx_Busy}, {31'b0, m_busy()});
    check("done",   {31'b0, Tx_Done}, {31'b0, m_done()});
    check("status", Status_Out,       {31'b0, m_busy()});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic we, input logic [1:0] sel, input logic [DW-1:0] wd);
    Write_Enable = we;
    Select       = sel;
    Write_Data   = wd;
    @(posedge clk);
    cyc++;
    model_edge(we, sel, wd);
    #1;
    Write_Enable = 1'b0;
    Select       = 2'b00;
    Write_Data   = '0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0);
  endtask

  // Optionally loads wd, starts a frame, and checks the serial image,
  // busy length and done pulse. inj_j > 0 injects a data write of 0xF0
  // at frame offset inj_j and a start one cycle later.
  task automatic run_frame(input bit write_first, input logic [DW-1:0] wd,
                           input logic [7:0] exp_byte, input string name, input int inj_j);
    logic [9:0] got_bits;
    logic [9:0] exp_bits;
    int busy_cnt, done_cnt, done_at, hold_bad;
    exp_bits = {1'b1, exp_byte, 1'b0};
    got_bits = '0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; hold_bad = 0;
    if (write_first) step(1'b1, 2'b01, wd);
    step(1'b1, 2'b11, 32'h1);
    for (int j = 0; j < FRAME + 3; j++) begin
      if (j > 0) begin
        if (j == inj_j)          step(1'b1, 2'b01, 32'hF0);
        else if (j == inj_j + 1) step(1'b1, 2'b11, 32'h1);
        else                     step(1'b0, 2'b00, '0);
      end
      if (Tx_Busy === 1'b1) busy_cnt++;
      if (Tx_Done === 1'b1) begin done_cnt++; done_at = j; end
      if (j < FRAME) begin
        if (j % CPB == CPB / 2) got_bits[j / CPB] = Tx;
        if (Tx !== exp_bits[j / CPB]) hold_bad++;
      end
    end
    check({name, "_serial"},   {22'b0, got_bits}, {22'b0, exp_bits});
    check({name, "_hold"},     hold_bad,  0);
    check({name, "_busylen"},  busy_cnt,  FRAME);
    check({name, "_donecnt"},  done_cnt,  1);
    check({name, "_doneat"},   done_at,   FRAME);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic          we;
    logic [1:0]    sel;
    logic [DW-1:0] wd;
    logic          exp_busy;
    logic          exp_tx;
  } acc_vec_t;

  typedef struct {
    logic [DW-1:0] wd;
    logic [7:0]    exp_byte;
  } frame_vec_t;

  acc_vec_t   acc_tab[7];
  frame_vec_t frm_tab[5];

  initial begin
    acc_tab[0] = '{1'b1, 2'b10, 32'h1,        1'b0, 1'b1};
    acc_tab[1] = '{1'b1, 2'b00, 32'h1,        1'b0, 1'b1};
    acc_tab[2] = '{1'b1, 2'b11, 32'hFFFFFFFE, 1'b0, 1'b1};
    acc_tab[3] = '{1'b0, 2'b11, 32'h1,        1'b0, 1'b1};
    acc_tab[4] = '{1'b0, 2'b01, 32'h33,       1'b0, 1'b1};
    acc_tab[5] = '{1'b1, 2'b01, 32'h5A,       1'b0, 1'b1};
    acc_tab[6] = '{1'b1, 2'b11, 32'h3,        1'b1, 1'b0};

    frm_tab[0] = '{32'h00000055, 8'h55};
    frm_tab[1] = '{32'hFFFFFFA3, 8'hA3};
    frm_tab[2] = '{32'h12345600, 8'h00};
    frm_tab[3] = '{32'h000000FF, 8'hFF};
    frm_tab[4] = '{32'hABCDEF96, 8'h96};

    // ---- reset behaviour ----
    reset = 1'b0;
    idle(3);
    #3 reset = 1'b1;
    check("rst_tx",     {31'b0, Tx},      32'h1);
    check("rst_busy",   {31'b0, Tx_Busy}, 32'h0);
    check("rst_status", Status_Out,       32'h0);
    check("rst_done",   {31'b0, Tx_Done}, 32'h0);
    idle(3);

    // ---- table: single-cycle accesses ----
    for (int i = 0; i < 7; i++) begin
      step(acc_tab[i].we, acc_tab[i].sel, acc_tab[i].wd);
      check($sformatf("acc%0d_busy", i), {31'b0, Tx_Busy}, {31'b0, acc_tab[i].exp_busy});
      check($sformatf("acc%0d_tx", i),   {31'b0, Tx},      {31'b0, acc_tab[i].exp_tx});
    end
    idle(FRAME + 2);

    // ---- table: full frames ----
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b1, frm_tab[i].wd, frm_tab[i].exp_byte, $sformatf("frm%0d", i), -1);
      idle(2);
    end

    // ---- start while busy: frame unchanged, no queued frame ----
    run_frame(1'b1, 32'h0F, 8'h0F, "busy_first", 10);
    begin
      int late_busy;
      late_busy = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step(1'b0, 2'b00, '0);
        if (Tx_Busy !== 1'b0) late_busy++;
      end
      check("busy_noqueue", late_busy, 0);
    end
    run_frame(1'b0, '0, 8'hF0, "busy_second", -1);
    idle(2);

    // ---- back-to-back: start on the done edge is dropped, next edge wins ----
    step(1'b1, 2'b01, 32'h3C);
    step(1'b1, 2'b11, 32'h1);
    idle(FRAME - 1);
    step(1'b1, 2'b11, 32'h1);
    check("b2b_done",  {31'b0, Tx_Done}, 32'h1);
    check("b2b_idle",  {31'b0, Tx_Busy}, 32'h0);
    check("b2b_gaptx", {31'b0, Tx},      32'h1);
    step(1'b1, 2'b11, 32'h1);
    check("b2b_restart_busy", {31'b0, Tx_Busy}, 32'h1);
    check("b2b_restart_tx",   {31'b0, Tx},      32'h0);
    idle(FRAME + 2);

    // ---- reset mid-frame during data bit 3 of 0x00 ----
    step(1'b1, 2'b01, 32'h00);
    step(1'b1, 2'b11, 32'h1);
    idle(4 * CPB + 1);
    check("mid_pre_tx", {31'b0, Tx}, 32'h0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_tx",     {31'b0, Tx},      32'h1);
    check("mid_rst_busy",   {31'b0, Tx_Busy}, 32'h0);
    check("mid_rst_status", Status_Out,       32'h0);
    idle(2);
    #3 reset = 1'b1;
    idle(2);
    run_frame(1'b1, 32'h81, 8'h81, "post_rst", -1);
    idle(2);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      logic          we;
      logic [1:0]    sel;
      logic [DW-1:0] wd;
      we  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      wd  = $urandom;
      if (sel == 2'b11 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      step(we, sel, wd);
    end
    idle(FRAME + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's store path, the write-side counterpart of the device read-back mux. A store decoded to the UART device codes loads a TX data register or issues a start command. The block then serializes the byte as 8N1 on the `Tx` pin. Busy status is returned on `Status_Out` for the core to poll through the read path.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the core store/read data bus
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Write_Enable`  in  1  store strobe from the core, one cycle per store
- `Select`  in  2  device code: 2'b01 = TX data, 2'b11 = TX control, 2'b10 = RX (ignored here), 2'b00 = not a UART access
- `Write_Data`  in  DATA_WIDTH  store data
- `Tx`  out  1  serial output; idles high
- `Tx_Busy`  out  1  high while a frame is in flight
- `Tx_Done`  out  1  one-cycle pulse at the end of a frame
- `Status_Out`  out  DATA_WIDTH  read-back value {(DATA_WIDTH-1)'b0, Tx_Busy}; combinational

## Operation
- Data write: `Write_Enable` and `Select`=01 loads `Write_Data[7:0]` into `tx_data_reg`. Upper bits are discarded. The load is accepted whether the block is busy or not.
- Start command: `Write_Enable`, `Select`=11 and `Write_Data[0]`=1, with state IDLE, accepts a start. `tx_data_reg` is copied into the shift register on that edge.
  - A start issued while not IDLE is dropped silently. It is not queued.
- A data write during a frame does not disturb the frame, because the shift register is a separate copy. The new value is sent on the next start.
- Writes with `Select`=00 or 10, and any cycle with `Write_Enable`=0, have no effect.
- State machine:
  - IDLE: `Tx`=1. Goes to START on an accepted start.
  - START: `Tx`=0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: `Tx`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. The bit index runs 0..7. After bit 7 completes, goes to STOP.
  - STOP: `Tx`=1 for CLKS_PER_BIT cycles, then goes to IDLE and pulses `Tx_Done`.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and clears on every state or bit change.
  - Bit index is 3 bits wide and wraps only by the state exit.
- `Tx_Busy` = (state != IDLE).
- `Tx` is driven from a flop, with no combinational glitches.

## Timing
- Reset (asynchronous assert) forces: `Tx`=1, `Tx_Busy`=0, `Tx_Done`=0, `Status_Out`=0, state IDLE, `tx_data_reg`=0, shift register 0, counters 0.
  - Reset asserted mid-frame aborts the frame immediately and drives `Tx` high without waiting for a clock.
- Let the start command be sampled at edge E0.
  - At E0: `Tx` falls and `Tx_Busy` rises.
  - Start bit occupies E0 through E0+CLKS_PER_BIT.
  - Data bit k occupies E0+(k+1)·CLKS_PER_BIT through E0+(k+2)·CLKS_PER_BIT.
  - Stop bit begins at E0+9·CLKS_PER_BIT.
- At edge E0+10·CLKS_PER_BIT: state returns to IDLE, `Tx_Busy` falls, and `Tx_Done` is high for exactly one cycle.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames:
  - A start at edge E0+10·CLKS_PER_BIT is not accepted, because state was still STOP when it was sampled.
  - The earliest accepted restart is E0+10·CLKS_PER_BIT+1, so there is at least one idle-high cycle between frames.
- A data write and start issued on consecutive cycles (data at E, start at E+1) sends the newly written byte.
- `Status_Out` follows `Tx_Busy` in the same cycle.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset behaviour: hold `reset`=0 for 3 cycles, then release. Require `Tx`=1, `Tx_Busy`=0, `Status_Out`=0x00000000, and `Tx_Done` never pulses.
- Basic frame: write 0x55 with `Select`=01, then start with `Select`=11 and data 0x1.
  - `Tx` must show 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - `Tx_Busy` must be high for exactly 40 cycles and `Status_Out`=0x1 during that time.
  - `Tx_Done` must be a single pulse as busy falls.
- Data width: write 0xFFFFFFA3, then start. The serial bits must be 1,1,0,0,0,1,0,1 (0xA3, LSB first), and upper bits are ignored.
- Start while busy: start a frame with 0x0F. At cycle 10, write 0xF0 with `Select`=01 and issue another start.
  - The first frame must complete unchanged as 0x0F.
  - No second frame may follow.
  - A start after busy falls must send 0xF0.
- Ignored accesses: issue a start write with `Select`=10, a start write with `Select`=00, and a start with `Write_Data[0]`=0. `Tx` must stay 1 and `Tx_Busy` must stay 0.
- Reset mid-frame: during data bit 3 of a 0x00 frame, assert `reset`=0 between clock edges.
  - `Tx` must go to 1 and `Tx_Busy` to 0 immediately.
  - After release, a new start of 0x81 must produce a clean 40-cycle frame.
